// File: rtl/e_mdu_if.sv
// e_mdu_if: pipeline <-> multiply/divide unit bundle.
//   start    : E-stage instruction is a valid MDU op this cycle
//   mdu_op   : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//              7 MFHI, 8 MFLO, 9-15 NONE
//   rs_data  : operand A / dividend / MTHI-MTLO source
//   rt_data  : operand B / divisor
//   busy     : mult/div in flight (registered)
//   rd_data  : HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi_out   : committed HI (debug/trace)
//   lo_out   : committed LO (debug/trace)
// master = pipeline side, slave = MDU side.
interface e_mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, mdu_op, rs_data, rt_data,
        input  busy, rd_data, hi_out, lo_out
    );

    modport slave (
        input  start, mdu_op, rs_data, rt_data,
        output busy, rd_data, hi_out, lo_out
    );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
// Mult/div results are computed at the accept edge into a pending register
// and committed to HI/LO only after MULT_CYCLES / DIV_CYCLES busy cycles, so
// the hazard unit sees realistic latency and no partial values are visible.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; aborts any in-flight op
//   mdu   : e_mdu_if.slave bundle (start/op/operands in, busy/rd/HI/LO out)
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave mdu
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mduOp_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    state_e        state;
    state_e        stateNext;
    logic [CW-1:0] count;
    logic [31:0]   hiReg;
    logic [31:0]   loReg;
    logic [31:0]   pendHi;
    logic [31:0]   pendLo;
    logic          pendWrite;

    logic          busyInt;
    logic          commit;
    logic          accept;
    logic          isMult;
    logic          isDiv;
    logic          isSigned;

    logic [63:0]   opA64;
    logic [63:0]   opB64;
    logic [63:0]   product;
    logic          negA;
    logic          negB;
    logic [31:0]   magA;
    logic [31:0]   magB;
    logic [31:0]   divisor;
    logic [31:0]   magQ;
    logic [31:0]   magR;
    logic [31:0]   quotient;
    logic [31:0]   remainder;

    // ------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------
    always_comb begin
        isMult   = (mdu.mdu_op == OP_MULT) || (mdu.mdu_op == OP_MULTU);
        isDiv    = (mdu.mdu_op == OP_DIV)  || (mdu.mdu_op == OP_DIVU);
        isSigned = (mdu.mdu_op == OP_MULT) || (mdu.mdu_op == OP_DIV);
        // Start is ignored for every op while a mult/div is in flight.
        accept   = mdu.start && !busyInt;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: begin
                if (accept && (isMult || isDiv)) begin
                    stateNext = S_RUN;
                end
            end
            S_RUN: begin
                if (count == '0) begin
                    stateNext = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busyInt = (state == S_RUN);
        commit  = (state == S_RUN) && (count == '0);
    end

    // ------------------------------------------------------------------
    // Multiply: extend to 64 bits first; the low 64 bits of the product
    // are then correct for both signed and unsigned operands.
    // ------------------------------------------------------------------
    always_comb begin
        opA64   = isSigned ? {{32{mdu.rs_data[31]}}, mdu.rs_data} : {32'd0, mdu.rs_data};
        opB64   = isSigned ? {{32{mdu.rt_data[31]}}, mdu.rt_data} : {32'd0, mdu.rt_data};
        product = opA64 * opB64;
    end

    // ------------------------------------------------------------------
    // Divide on magnitudes, then restore signs: quotient negative when
    // operand signs differ, remainder follows the dividend. Working on
    // magnitudes makes 0x80000000 / -1 come out as 0x80000000 rem 0
    // without a signed-overflow corner. A zero divisor is replaced by 1
    // only to keep the divider defined; its result is never committed.
    // ------------------------------------------------------------------
    always_comb begin
        negA      = isSigned && mdu.rs_data[31];
        negB      = isSigned && mdu.rt_data[31];
        magA      = negA ? (~mdu.rs_data + 32'd1) : mdu.rs_data;
        magB      = negB ? (~mdu.rt_data + 32'd1) : mdu.rt_data;
        divisor   = (mdu.rt_data == '0) ? 32'd1 : magB;
        magQ      = magA / divisor;
        magR      = magA % divisor;
        quotient  = (negA ^ negB) ? (~magQ + 32'd1) : magQ;
        remainder = negA ? (~magR + 32'd1) : magR;
    end

    // ------------------------------------------------------------------
    // HI/LO, pending result and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hiReg     <= '0;
            loReg     <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendWrite <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            case (mdu.mdu_op)
                OP_MTHI: hiReg <= mdu.rs_data;
                OP_MTLO: loReg <= mdu.rs_data;
                OP_MULT, OP_MULTU: begin
                    count     <= MULT_LOAD;
                    pendHi    <= product[63:32];
                    pendLo    <= product[31:0];
                    pendWrite <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    count     <= DIV_LOAD;
                    pendHi    <= remainder;
                    pendLo    <= quotient;
                    pendWrite <= (mdu.rt_data != '0);
                end
                default: ;
            endcase
        end else if (busyInt) begin
            if (commit) begin
                if (pendWrite) begin
                    hiReg <= pendHi;
                    loReg <= pendLo;
                end
                pendWrite <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mdu.rd_data = '0;
        if (mdu.mdu_op == OP_MFHI) begin
            mdu.rd_data = hiReg;
        end else if (mdu.mdu_op == OP_MFLO) begin
            mdu.rd_data = loReg;
        end
    end

    assign mdu.busy   = busyInt;
    assign mdu.hi_out = hiReg;
    assign mdu.lo_out = loReg;

endmodule
